branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Dynamic branch predictor and redirect controller for the 5-stage RV32I pipeline. In F it looks up
//  PCF in a direct-mapped BTB with 2-bit saturating counters and supplies the next fetch PC.
//  In E it compares the branch unit's resolved outcome (branchTakenE) with the carried prediction.
//  It flags a mispredict, supplies the redirect PC, trains the table and keeps perf counters.
// PARAMETERS
//  XLEN     32  datapath/PC width
//  ENTRIES  64  BTB entries; power of 2, >=2. IDX_W=$clog2(ENTRIES), TAG_W=XLEN-IDX_W-2
//  CNT_W    32  perf counter width
// PORTS
//  clk              in   1      clock, all state updates on rising edge
//  reset            in   1      synchronous, active-high
//  PCF              in   XLEN   fetch PC
//  predTakenF       out  1      prediction for PCF (pipelined to E by datapath)
//  nextPCF          out  XLEN   predicted next fetch PC; predTargetF is this value when predTakenF=1
//  resolveE         in   1      valid control-transfer instr in E; hazard unit drives 0 on bubble/stall
//  branchE          in   1      E instr is conditional branch
//  jumpE            in   1      E instr is jal/jalr
//  branchTakenE     in   1      branch unit outcome
//  PCE              in   XLEN   PC of E instr
//  PCTargetE        in   XLEN   computed target (branch/jal/jalr)
//  predTakenE       in   1      predTakenF carried to E
//  predTargetE      in   XLEN   nextPCF carried to E
//  mispredictE      out  1      redirect + flush D/E this cycle
//  redirectPCE      out  XLEN   correct next PC when mispredictE=1
//  branchCount      out  CNT_W  resolved control transfers
//  mispredictCount  out  CNT_W  mispredicts
// BEHAVIOUR
//  - Index idx=PC[IDX_W+1:2], tag=PC[XLEN-1:IDX_W+2]. Entry: valid, tag, target, isJump, ctr[1:0].
//  - F lookup is combinational, zero latency: hit=valid[idx]&&tag match.
//    predTakenF=hit&&(isJump||ctr[1]); nextPCF=predTakenF?target:PCF+4.
//    predTakenF=0, nextPCF=PCF+4 while reset=1.
//  - E check is combinational: actual=jumpE|(branchE&branchTakenE).
//    mispredictE=resolveE&&(actual!=predTakenE || (actual&&predTargetE!=PCTargetE)).
//    redirectPCE=actual?PCTargetE:PCE+4, driven regardless of mispredictE.
//  - Update occurs on the clock edge with resolveE=1 and reset=0, indexed by PCE:
//    actual & hit: target<=PCTargetE, isJump<=jumpE, ctr<=sat_inc(ctr).
//    actual & miss: allocate/overwrite; valid<=1, tag, target, isJump<=jumpE, ctr<=jumpE?ST:WT.
//    !actual & hit: ctr<=sat_dec(ctr) (floor SNT). !actual & miss: no change.
//  - Counter encoding: SNT=00, WNT=01, WT=10, ST=11. Counters saturate at 11 and 00, with no wrap.
//  - Same-cycle F read and E write to one idx: F sees the old entry; the write is visible next cycle. No bypass.
//  - Perf counters: branchCount++ per resolveE; mispredictCount++ per mispredictE. Both saturate at all-ones.
//  - Reset, including mid-operation: all valid<=0, all ctr<=WNT, perf counters<=0.
//    No table update in the reset cycle even if resolveE=1. Tag/target arrays are not reset.
//  - PC+4 arithmetic is modulo 2^XLEN, so 0xFFFFFFFC+4 wraps to 0.
// STRUCTURE
//  - Package bp_pkg: typedef enum logic[1:0] bp_ctr_t {SNT,WNT,WT,ST}; functions sat_inc/sat_dec;
//    typedef struct btb_entry_t {tag, target, isJump}.
//  - valid and ctr arrays are resettable flops; tag/target/isJump form a plain array inferable as LUTRAM.
//  - One sub-module: sat_counter #(W): clk, reset, en, q. Used for both perf counters.
// TESTING (ENTRIES=64)
//  1 Reset, then PCF=0x100 -> predTakenF=0, nextPCF=0x104; counts 0.
//  2 resolveE,branchE,branchTakenE=1, PCE=0x100, PCTargetE=0x80, predTakenE=0
//    -> mispredictE=1, redirectPCE=0x80. Next cycle PCF=0x100 -> predTakenF=1, nextPCF=0x80.
//  3 Then resolve 0x100 not-taken, predTakenE=1, predTargetE=0x80
//    -> mispredictE=1, redirectPCE=0x104, ctr WT->WNT. PCF=0x100 -> predTakenF=0, nextPCF=0x104.
//  4 Alias: PCF=0x200 (idx 0, different tag) while 0x100 entry valid -> predTakenF=0, nextPCF=0x204.
//  5 jalr PCE=0x40, PCTargetE=0x300, predTakenE=1, predTargetE=0x280
//    -> mispredictE=1, redirectPCE=0x300. PCF=0x40 -> nextPCF=0x300.
//  6 Four taken hits -> ctr held at ST. Then assert reset with resolveE=1
//    -> no update, predTakenF=0 for all PCs, branchCount=mispredictCount=0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: counter encoding,
// saturating counter arithmetic and the BTB entry layout.
package bp_pkg;

   localparam int BP_XLEN    = 32;
   localparam int BP_ENTRIES = 64;
   localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
   localparam int BP_TAG_W   = BP_XLEN - BP_IDX_W - 2;

   // Two-bit direction counter; the MSB is the taken prediction.
   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_t;

   // Non-reset portion of a BTB entry; valid and counter live in flops.
   typedef struct packed {
      logic [BP_TAG_W-1:0] tag;
      logic [BP_XLEN-1:0]  target;
      logic                is_jump;
   } btb_entry_t;

   function automatic bp_ctr_t sat_inc(input bp_ctr_t c);
      case (c)
         SNT:     return WNT;
         WNT:     return WT;
         default: return ST;
      endcase
   endfunction

   function automatic bp_ctr_t sat_dec(input bp_ctr_t c);
      case (c)
         ST:      return WT;
         WT:      return WNT;
         default: return SNT;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: increment on enable unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency fetch
// prediction, execute-stage mispredict detection and redirect, table
// training and performance counters. The BTB entry layout comes from
// bp_pkg, so XLEN/ENTRIES must match the package constants.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int XLEN    = BP_XLEN,
   parameter int ENTRIES = BP_ENTRIES,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  PCF,
   output logic             predTakenF,
   output logic [XLEN-1:0]  nextPCF,
   input  logic             resolveE,
   input  logic             branchE,
   input  logic             jumpE,
   input  logic             branchTakenE,
   input  logic [XLEN-1:0]  PCE,
   input  logic [XLEN-1:0]  PCTargetE,
   input  logic             predTakenE,
   input  logic [XLEN-1:0]  predTargetE,
   output logic             mispredictE,
   output logic [XLEN-1:0]  redirectPCE,
   output logic [CNT_W-1:0] branchCount,
   output logic [CNT_W-1:0] mispredictCount
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic       valid_q [ENTRIES];
   bp_ctr_t    ctr_q   [ENTRIES];
   btb_entry_t btb_mem [ENTRIES];

   // Fetch-side lookup
   logic [IDX_W-1:0] idx_f;
   logic [TAG_W-1:0] tag_f;
   btb_entry_t       entry_f;
   bp_ctr_t          ctr_f;
   logic             hit_f;

   assign idx_f   = PCF[IDX_W+1:2];
   assign tag_f   = PCF[XLEN-1:IDX_W+2];
   assign entry_f = btb_mem[idx_f];
   assign ctr_f   = ctr_q[idx_f];
   assign hit_f   = valid_q[idx_f] && (entry_f.tag == tag_f);

   assign predTakenF = !reset && hit_f && (entry_f.is_jump || ctr_f[1]);
   assign nextPCF    = predTakenF ? entry_f.target : (PCF + XLEN'(4));

   // Execute-side check
   logic [IDX_W-1:0] idx_e;
   logic [TAG_W-1:0] tag_e;
   logic [TAG_W-1:0] stored_tag_e;
   bp_ctr_t          ctr_e;
   bp_ctr_t          ctr_d;
   logic             hit_e;
   logic             actual_e;
   logic             upd_en;

   assign idx_e        = PCE[IDX_W+1:2];
   assign tag_e        = PCE[XLEN-1:IDX_W+2];
   assign stored_tag_e = btb_mem[idx_e].tag;
   assign ctr_e        = ctr_q[idx_e];
   assign hit_e        = valid_q[idx_e] && (stored_tag_e == tag_e);
   assign actual_e     = jumpE | (branchE & branchTakenE);
   assign upd_en       = resolveE && !reset;

   assign mispredictE = resolveE &&
                        ((actual_e != predTakenE) ||
                         (actual_e && (predTargetE != PCTargetE)));
   assign redirectPCE = actual_e ? PCTargetE : (PCE + XLEN'(4));

   // New counter value for the entry addressed by PCE.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      ctr_d = ctr_e;
      if (actual_e) begin
         if (hit_e) begin
            ctr_d = sat_inc(ctr_e);
         end else begin
            ctr_d = jumpE ? ST : WT;
         end
      end else if (hit_e) begin
         ctr_d = sat_dec(ctr_e);
      end
   end

   // Resettable valid bits and direction counters.
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= WNT;
         end
      end else if (upd_en && (actual_e || hit_e)) begin
         if (actual_e) begin
            valid_q[idx_e] <= 1'b1;
         end
         ctr_q[idx_e] <= ctr_d;
      end
   end

   // Tag/target/type storage written on every taken resolution.
   // NOTE: this array is deliberately not reset so it can map to distributed RAM; valid_q guards its contents.
   always_ff @(posedge clk) begin
      if (upd_en && actual_e) begin
         btb_mem[idx_e] <= '{tag: tag_e, target: PCTargetE, is_jump: jumpE};
      end
   end

   sat_counter #(.W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (resolveE),
      .q     (branchCount)
   );

   sat_counter #(.W(CNT_W)) u_mispredict_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (mispredictE),
      .q     (mispredictCount)
   );

endmodule
